// File: rtl/tcam_route_lookup_if.sv
// rtl/tcam_route_lookup_if.sv - lookup request/result handshake bundle for tcam_route_lookup
interface tcam_route_lookup_if #(
    parameter int ID_WIDTH     = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int ADDR_WIDTH   = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic [ID_WIDTH-1:0]     in_id;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_hit;
    logic                    out_multi;
    logic [ADDR_WIDTH-1:0]   out_index;
    logic [ID_WIDTH-1:0]     out_dst;
    logic [WEIGHT_WIDTH-1:0] out_weight;

    modport master (
        output in_valid, in_id, out_ready,
        input  in_ready, out_valid, out_hit, out_multi, out_index, out_dst, out_weight
    );

    modport slave (
        input  in_valid, in_id, out_ready,
        output in_ready, out_valid, out_hit, out_multi, out_index, out_dst, out_weight
    );
endinterface

// File: rtl/tcam_route_lookup.sv
// rtl/tcam_route_lookup.sv - two-stage ternary-match route lookup with lowest-index priority and hit/miss statistics
module tcam_route_lookup #(
    parameter int ID_WIDTH     = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int WORDS        = 16,
    parameter int ADDR_WIDTH   = $clog2(WORDS),
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    tcam_route_lookup_if.slave      lk,
    input  logic                    cfg_we,
    input  logic [ADDR_WIDTH-1:0]   cfg_addr,
    input  logic [ID_WIDTH-1:0]     cfg_key,
    input  logic [ID_WIDTH-1:0]     cfg_mask,
    input  logic [ID_WIDTH-1:0]     cfg_dst,
    input  logic [WEIGHT_WIDTH-1:0] cfg_weight,
    input  logic                    cfg_vld,
    input  logic                    flush,
    input  logic                    cnt_clr,
    output logic [CNT_WIDTH-1:0]    hit_cnt,
    output logic [CNT_WIDTH-1:0]    miss_cnt
);
    logic [ID_WIDTH-1:0]     tbl_key    [WORDS];
    logic [ID_WIDTH-1:0]     tbl_mask   [WORDS];
    logic [ID_WIDTH-1:0]     tbl_dst    [WORDS];
    logic [WEIGHT_WIDTH-1:0] tbl_weight [WORDS];
    logic [WORDS-1:0]        tbl_valid;

    logic                    s1_valid;
    logic [ID_WIDTH-1:0]     s1_id;
    logic                    s1_advance;
    logic                    accept;

    logic [WORDS-1:0]        match;
    logic                    enc_hit;
    logic                    enc_multi;
    logic [ADDR_WIDTH-1:0]   enc_index;
    logic [ID_WIDTH-1:0]     enc_dst;
    logic [WEIGHT_WIDTH-1:0] enc_weight;

    assign s1_advance  = !lk.out_valid || lk.out_ready;
    assign lk.in_ready = !cfg_we && !flush && (!s1_valid || s1_advance);
    assign accept      = lk.in_valid && lk.in_ready;

    // S1 is compared against the live table every cycle, so a stalled request sees later table edits.
    always_comb begin
        match      = '0;
        enc_index  = '0;
        enc_dst    = '0;
        enc_weight = '0;
        for (int i = 0; i < WORDS; i++) begin
            match[i] = tbl_valid[i] && (((s1_id ^ tbl_key[i]) & tbl_mask[i]) == '0);
        end
        enc_hit   = |match;
        enc_multi = (match & (match - WORDS'(1))) != '0;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (match[i]) begin
                enc_index  = ADDR_WIDTH'(i);
                enc_dst    = tbl_dst[i];
                enc_weight = tbl_weight[i];
            end
        end
    end

    // Flush overrides a same-edge write to the valid bit; other fields still take the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_valid <= '0;
            for (int i = 0; i < WORDS; i++) begin
                tbl_key[i]    <= '0;
                tbl_mask[i]   <= '0;
                tbl_dst[i]    <= '0;
                tbl_weight[i] <= '0;
            end
        end else begin
            if (cfg_we) begin
                tbl_key[cfg_addr]    <= cfg_key;
                tbl_mask[cfg_addr]   <= cfg_mask;
                tbl_dst[cfg_addr]    <= cfg_dst;
                tbl_weight[cfg_addr] <= cfg_weight;
                tbl_valid[cfg_addr]  <= cfg_vld;
            end
            if (flush) begin
                tbl_valid <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_id    <= lk.in_id;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk.out_valid  <= 1'b0;
            lk.out_hit    <= 1'b0;
            lk.out_multi  <= 1'b0;
            lk.out_index  <= '0;
            lk.out_dst    <= '0;
            lk.out_weight <= '0;
        end else if (s1_advance) begin
            lk.out_valid <= s1_valid;
            if (s1_valid) begin
                lk.out_hit    <= enc_hit;
                lk.out_multi  <= enc_multi;
                lk.out_index  <= enc_index;
                lk.out_dst    <= enc_dst;
                lk.out_weight <= enc_weight;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (cnt_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (s1_advance && s1_valid) begin
            if (enc_hit && hit_cnt != '1) begin
                hit_cnt <= hit_cnt + CNT_WIDTH'(1);
            end
            if (!enc_hit && miss_cnt != '1) begin
                miss_cnt <= miss_cnt + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_tcam_route_lookup.sv
// tb/tb_tcam_route_lookup.sv - scoreboard bench for tcam_route_lookup with directed vectors
module tb_tcam_route_lookup;
    typedef struct packed {
        logic       hit;
        logic       multi;
        logic [3:0] index;
        logic [3:0] dst;
        logic [3:0] weight;
    } res_t;

    localparam res_t MISS = '{hit: 1'b0, multi: 1'b0, index: 4'h0, dst: 4'h0, weight: 4'h0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_addr = '0, cfg_key = '0, cfg_mask = '0, cfg_dst = '0, cfg_weight = '0;
    logic       cfg_vld = 1'b0;
    logic       flush = 1'b0;
    logic       cnt_clr = 1'b0;
    logic [3:0] hit_cnt, miss_cnt;

    int total = 0;
    int bad = 0;
    res_t sb[$];

    tcam_route_lookup_if #(.ID_WIDTH(4), .WEIGHT_WIDTH(4), .ADDR_WIDTH(4)) bus ();

    tcam_route_lookup #(
        .ID_WIDTH(4), .WEIGHT_WIDTH(4), .WORDS(16), .ADDR_WIDTH(4), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst), .lk(bus),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_key(cfg_key), .cfg_mask(cfg_mask),
        .cfg_dst(cfg_dst), .cfg_weight(cfg_weight), .cfg_vld(cfg_vld),
        .flush(flush), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: result ordering, stall stability and in_ready back-pressure.
    logic stalled = 1'b0;
    res_t snap;
    always @(negedge clk) begin
        res_t cur;
        res_t exp;
        cur = '{hit: bus.out_hit, multi: bus.out_multi, index: bus.out_index,
                dst: bus.out_dst, weight: bus.out_weight};
        if (!rst) begin
            if (stalled) begin
                chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
                chk("stall_hold", {16'd0, cur}, {16'd0, snap});
            end
            if (bus.out_valid && !bus.out_ready && sb.size() >= 2)
                chk("in_ready_stall", {31'd0, bus.in_ready}, 32'd0);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    exp = sb.pop_front();
                    chk("result", {16'd0, cur}, {16'd0, exp});
                end
            end
        end
        stalled = !rst && bus.out_valid && !bus.out_ready;
        snap = cur;
    end

    task automatic send(input logic [3:0] id, input res_t e);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_id = id;
        @(negedge clk);
        while (!bus.in_ready) begin
            n++;
            if (n > 200) begin
                chk("accept_timeout", 32'd0, 32'd1);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        sb.push_back(e);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [3:0] k, input logic [3:0] m,
                             input logic [3:0] d, input logic [3:0] w, input logic v);
        cfg_we = 1'b1; cfg_addr = a; cfg_key = k; cfg_mask = m;
        cfg_dst = d; cfg_weight = w; cfg_vld = v;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    localparam res_t R5 = '{hit: 1'b1, multi: 1'b0, index: 4'd3, dst: 4'hA, weight: 4'h2};
    localparam res_t R9 = '{hit: 1'b1, multi: 1'b1, index: 4'd2, dst: 4'h4, weight: 4'h0};
    localparam res_t RC = '{hit: 1'b1, multi: 1'b0, index: 4'd7, dst: 4'h1, weight: 4'h0};
    localparam res_t R0 = '{hit: 1'b1, multi: 1'b0, index: 4'd0, dst: 4'h5, weight: 4'h7};

    logic [3:0] st_id  [8];
    res_t       st_res [8];
    logic       pat    [4];

    initial begin
        bus.in_valid = 1'b0;
        bus.in_id = '0;
        bus.out_ready = 1'b1;
        st_id  = '{4'h5, 4'h9, 4'h6, 4'hC, 4'hC, 4'h5, 4'h9, 4'h6};
        st_res = '{R5, R9, MISS, RC, RC, R5, R9, MISS};
        pat    = '{1'b1, 1'b0, 1'b0, 1'b1};

        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_hit_cnt", {28'd0, hit_cnt}, 32'd0);
        chk("rst_miss_cnt", {28'd0, miss_cnt}, 32'd0);
        #20 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Basic hit and miss.
        cfg_write(4'd3, 4'h5, 4'hF, 4'hA, 4'h2, 1'b1);
        send(4'h5, R5);
        drain();
        chk("t1_hit_cnt", {28'd0, hit_cnt}, 32'd1);
        send(4'h6, MISS);
        drain();
        chk("t1_miss_cnt", {28'd0, miss_cnt}, 32'd1);

        // Lowest index wins; multi flag.
        cfg_write(4'd7, 4'h8, 4'h8, 4'h1, 4'h0, 1'b1);
        cfg_write(4'd2, 4'h9, 4'hF, 4'h4, 4'h0, 1'b1);
        send(4'h9, R9);
        send(4'hC, RC);
        drain();
        chk("t2_hit_cnt", {28'd0, hit_cnt}, 32'd3);

        // Streaming under 1,0,0,1 back-pressure.
        fork
            begin
                for (int i = 0; i < 8; i++) send(st_id[i], st_res[i]);
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    @(posedge clk);
                    #1 bus.out_ready = pat[k % 4];
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();
        chk("t3_hit_cnt", {28'd0, hit_cnt}, 32'd9);
        chk("t3_miss_cnt", {28'd0, miss_cnt}, 32'd3);

        // Config blocks acceptance.
        cfg_we = 1'b1; cfg_addr = 4'd15; cfg_key = 4'h0; cfg_mask = 4'h0; cfg_vld = 1'b0;
        bus.in_valid = 1'b1; bus.in_id = 4'h5;
        @(negedge clk);
        chk("t4_cfg_block", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1 cfg_we = 1'b0; bus.in_valid = 1'b0;

        // Invalidate one edge after acceptance does not affect that result.
        send(4'h5, R5);
        cfg_write(4'd3, 4'h5, 4'hF, 4'hA, 4'h2, 1'b0);
        drain();
        send(4'h5, MISS);
        drain();

        // Flush beats a same-edge write.
        flush = 1'b1;
        cfg_we = 1'b1; cfg_addr = 4'd4; cfg_key = 4'h0; cfg_mask = 4'h0;
        cfg_dst = 4'h3; cfg_weight = 4'h1; cfg_vld = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; cfg_we = 1'b0;
        send(4'h9, MISS);
        send(4'hC, MISS);
        drain();
        chk("t4_miss_cnt", {28'd0, miss_cnt}, 32'd6);

        // Counter saturation and clear priority.
        cfg_write(4'd0, 4'h0, 4'h0, 4'h5, 4'h7, 1'b1);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        chk("t5_clr_hit", {28'd0, hit_cnt}, 32'd0);
        chk("t5_clr_miss", {28'd0, miss_cnt}, 32'd0);
        for (int i = 0; i < 20; i++) send(4'(i), R0);
        drain();
        chk("t5_hit_sat", {28'd0, hit_cnt}, 32'd15);
        chk("t5_miss_zero", {28'd0, miss_cnt}, 32'd0);
        send(4'h1, R0);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        chk("t5_clr_wins", {28'd0, hit_cnt}, 32'd0);
        drain();

        // Asynchronous reset with S1 and S2 occupied.
        bus.out_ready = 1'b0;
        send(4'h1, R0);
        send(4'h2, R0);
        chk("t6_pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t6_rst_hit_cnt", {28'd0, hit_cnt}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        chk("t6_in_ready", {31'd0, bus.in_ready}, 32'd1);
        send(4'h1, MISS);
        drain();
        chk("t6_miss_cnt", {28'd0, miss_cnt}, 32'd1);
        chk("t6_hit_cnt", {28'd0, hit_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tcam_route_lookup.md
# tcam_route_lookup

Parametrised ternary-match routing lookup engine for the packet router. Holds a behavioural TCAM table of `WORDS` entries, each with key, care-mask, destination ID, weight and valid bit. Accepts a stream of packet IDs over a valid/ready handshake and returns destination, weight, hit and multi-hit flags two edges later, with full back-pressure. It replaces the hard-macro lookup with a generic, depth-scalable block that adds a pipelined handshake, per-entry invalidate, bulk flush and hit/miss statistics.

## Interface
- `ID_WIDTH`, 4: packet/destination ID width; the lookup key is `ID_WIDTH` bits.
- `WEIGHT_WIDTH`, 4: weight field width.
- `WORDS`, 16: table depth, ≥2.
- `ADDR_WIDTH`, $clog2(WORDS): entry index width.
- `CNT_WIDTH`, 16: statistics counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1 / `in_ready` out 1 / `in_id` in ID_WIDTH: lookup request.
- `out_valid` out 1 / `out_ready` in 1: result handshake.
- `out_hit` out 1: at least one valid entry matched.
- `out_multi` out 1: two or more valid entries matched.
- `out_index` out ADDR_WIDTH: winning entry index.
- `out_dst` out ID_WIDTH: winning destination ID.
- `out_weight` out WEIGHT_WIDTH: winning weight.
- `cfg_we` in 1: write the entry at `cfg_addr`.
- `cfg_addr` in ADDR_WIDTH: entry index for `cfg_we`.
- `cfg_key` in ID_WIDTH: key field written by `cfg_we`.
- `cfg_mask` in ID_WIDTH: care-mask field; a 1 bit means the key bit is compared.
- `cfg_dst` in ID_WIDTH: destination field written by `cfg_we`.
- `cfg_weight` in WEIGHT_WIDTH: weight field written by `cfg_we`.
- `cfg_vld` in 1: valid bit written by `cfg_we`; 0 invalidates the entry.
- `flush` in 1: clear all valid bits.
- `cnt_clr` in 1: clear both statistics counters.
- `hit_cnt` out CNT_WIDTH / `miss_cnt` out CNT_WIDTH: statistics counters.

## Operation
- Match rule for entry i: `valid[i] && ((in_key ^ key[i]) & mask[i]) == 0`. A mask of all zeros matches any key.
- Priority: the lowest matching index wins. On a miss, `out_index`, `out_dst` and `out_weight` are 0 and `out_hit` is 0.
- Pipeline, two register stages:
  - S1 holds the accepted ID and its valid bit.
  - S2 is the output register. It is loaded with the compare and encode result computed combinationally from S1 and the current table.
- S1 advances into S2 when `!out_valid || out_ready`.
- `in_ready = !cfg_we && !flush && (!s1_valid || s1_advance)`. Configuration and lookup acceptance never coincide.
- `cfg_we` updates all fields of entry `cfg_addr` at the edge.
- `flush` clears every valid bit at the edge; key, mask, dst and weight are retained.
- `flush` and `cfg_we` asserted together: flush wins for every entry, including the addressed one.
- Counters update whenever S2 is loaded: `hit_cnt` on a hit, `miss_cnt` on a miss. Both saturate at all-ones.
- `cnt_clr` zeroes both counters and takes priority over a same-edge increment.
- Reset values:
  - `out_valid`, `s1_valid` = 0.
  - `out_*` data outputs = 0.
  - All table fields and valid bits = 0.
  - Both counters = 0.
  - `in_ready` = 1 once `rst` is released, provided `cfg_we` and `flush` are low.

## Timing
- Latency: a request accepted at edge N is visible on `out_valid` and the result outputs after edge N+1 if S2 is free.
- Throughput is one lookup per cycle with `out_ready` held high.
- Table visibility: a result reflects the table as it stands between edges N and N+1. A `cfg_we` or `flush` at edge N+1 does not affect the result loaded at N+1; it does affect any later S1 occupant.
- Back-pressure: while `out_valid && !out_ready`:
  - S2 holds all result fields stable.
  - S1 holds its request and, if valid, is re-compared against the current table every cycle until it advances.
  - `in_ready` is 0 while S1 is valid.
- `rst` asserted mid-operation asynchronously drops all in-flight requests and clears the table. No result is produced for dropped requests.
- `out_valid` never drops without a handshake except on reset.

## Test plan
1. Reset, then write entry 3 (key=0x5, mask=0xF, dst=0xA, weight=0x2, vld=1). Look up 0x5 → after edge N+1: `out_hit=1`, `out_index=3`, `out_dst=0xA`, `out_weight=0x2`, `hit_cnt=1`. Look up 0x6 → `out_hit=0`, all result fields 0, `miss_cnt=1`.
2. Priority: entry 7 (key=0x8, mask=0x8, dst=0x1) and entry 2 (key=0x9, mask=0xF, dst=0x4). Look up 0x9 → `out_index=2`, `out_dst=0x4`, `out_multi=1`. Look up 0xC → `out_index=7`, `out_multi=0`.
3. Streaming with back-pressure: 8 back-to-back lookups while `out_ready` toggles in the pattern 1,0,0,1. All 8 results arrive in order, S2 fields stay stable while stalled, and `in_ready` deasserts during stalls.
4. Config collision: hold `cfg_we` and `in_valid` together → `in_ready=0`. A lookup accepted at edge N with an invalidate of its matching entry at N+1 still reports a hit. A `flush` and `cfg_we` (vld=1) on the same edge leave all valid bits 0.
5. Counters: preset `CNT_WIDTH=4`, run 20 hits → `hit_cnt=15`, saturated. `cnt_clr` on the same edge as a hit → `hit_cnt=0`.
6. Assert `rst` asynchronously mid-stream with S1 and S2 occupied → `out_valid=0` immediately, table empty, and a subsequent lookup misses.
